// File: rtl/pt_stream_reader.sv
// pt_stream_reader
//   Reads a length-prefixed message from the plaintext memory (address 0 =
//   length L, addresses 1..L = bytes), streams each byte over a valid/ready
//   handshake and reports whether every byte was printable.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   en           : start request, honoured only while rdy=1
//   rdy          : idle / pt_ok valid
//   pt_addr      : registered read address into the plaintext memory
//   pt_rddata    : read data, valid the cycle after the address was registered
//   out_valid    : out_data holds a message byte
//   out_data     : message byte
//   out_ready    : downstream accept
//   pt_ok        : 1 when every byte of the last message was in [LO_CHAR, HI_CHAR]
module pt_stream_reader #(
    parameter logic [7:0] LO_CHAR = 8'h20,
    parameter logic [7:0] HI_CHAR = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       pt_ok
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LEN,
        LEN,
        WAIT_B,
        BYTE,
        OUT,
        FIN
    } state_t;

    state_t     state;
    logic [7:0] idx;
    logic [7:0] len;
    logic       acc;
    logic       in_range;

    assign in_range = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            pt_addr   <= 8'h00;
            pt_ok     <= 1'b0;
            idx       <= 8'h00;
            len       <= 8'h00;
            acc       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        pt_addr <= 8'h00;
                        rdy     <= 1'b0;
                        pt_ok   <= 1'b0;
                        acc     <= 1'b1;
                        state   <= WAIT_LEN;
                    end
                end
                WAIT_LEN: state <= LEN;
                LEN: begin
                    len <= pt_rddata;
                    if (pt_rddata == 8'h00) begin
                        state <= FIN;
                    end else begin
                        idx     <= 8'h01;
                        pt_addr <= 8'h01;
                        state   <= WAIT_B;
                    end
                end
                WAIT_B: state <= BYTE;
                BYTE: begin
                    out_data  <= pt_rddata;
                    out_valid <= 1'b1;
                    acc       <= acc & in_range;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // compare before increment so L=255 stops at 255
                        if (idx == len) begin
                            state <= FIN;
                        end else begin
                            idx     <= idx + 8'h01;
                            pt_addr <= idx + 8'h01;
                            state   <= WAIT_B;
                        end
                    end
                end
                FIN: begin
                    pt_ok <= acc;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pt_stream_reader.sv
// tb_pt_stream_reader
//   Directed plus randomized bench for pt_stream_reader. A synchronous-read
//   memory model feeds the DUT; expected bytes, pt_ok and completion latency
//   are derived from the memory image and the driven out_ready pattern.
module tb_pt_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       pt_ok;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] got [$];
    int         max_addr = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_rdy = 1'b0;
    logic       prev_ok = 1'b0;
    logic       prev_rst = 1'b1;

    always #5 clk = ~clk;

    pt_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .pt_ok     (pt_ok)
    );

    always @(posedge clk) pt_rddata <= mem[pt_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: collects transferred bytes, checks stall stability,
    // pt_ok stability while idle and tracks the highest address read.
    always @(negedge clk) begin
        if (!rst && prev_stall) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", {24'b0, out_data}, {24'b0, prev_data});
        end
        if (!prev_rst && prev_rdy && rdy)
            chk("ok_stable", {31'b0, pt_ok}, {31'b0, prev_ok});
        if (!rst && out_valid && out_ready) got.push_back(out_data);
        if (!rst && !rdy && int'(pt_addr) > max_addr) max_addr = int'(pt_addr);
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        prev_rdy   = rdy;
        prev_ok    = pt_ok;
        prev_rst   = rst;
    end

    function automatic bit printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    // mode 0: out_ready=1; mode 1: random out_ready; mode 2: 5-cycle stall on first byte
    task automatic run_msg(input int L, input int mode, input bit en_mid, input string tag);
        int cycles = 0;
        int stalls = 0;
        int stall_left = (mode == 2) ? 5 : 0;
        bit ok_m = 1'b1;
        bit done = 1'b0;
        for (int i = 1; i <= L; i++) ok_m &= printable(mem[i]);
        got.delete();
        max_addr = 0;
        chk({tag, "_rdy_before"}, {31'b0, rdy}, 32'd1);
        en = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        chk({tag, "_rdy_start"}, {31'b0, rdy}, 32'd0);
        chk({tag, "_ok_start"}, {31'b0, pt_ok}, 32'd0);
        for (int c = 1; c <= 2000 && !done; c++) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else out_ready = 1'b1;
            if (out_valid && !out_ready) stalls++;
            en = en_mid && (c == 6);
            @(posedge clk); #1;
            if (rdy) begin
                done = 1'b1;
                cycles = c;
            end
        end
        en = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_latency"}, cycles, 3 + 3 * L + stalls);
        if (mode == 2) chk({tag, "_stalls"}, stalls, 32'd5);
        chk({tag, "_nbytes"}, got.size(), L);
        for (int i = 0; i < L && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'b0, got[i]}, {24'b0, mem[i + 1]});
        chk({tag, "_pt_ok"}, {31'b0, pt_ok}, {31'b0, ok_m});
        chk({tag, "_max_addr"}, max_addr, L);
    endtask

    task automatic load(input logic [7:0] b [$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < b.size(); i++) mem[i] = b[i];
    endtask

    initial begin
        logic [7:0] img [$];
        bit hit;

        // reset with en held high, then idle
        load('{8'h00});
        rst = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                rst = 1'b0;
                en = 1'b0;
            end
            @(posedge clk); #1;
            chk("idle_rdy", {31'b0, rdy}, 32'd1);
            chk("idle_valid", {31'b0, out_valid}, 32'd0);
            chk("idle_ok", {31'b0, pt_ok}, 32'd0);
            chk("idle_addr", {24'b0, pt_addr}, 32'd0);
        end

        // empty message
        load('{8'h00});
        run_msg(0, 0, 1'b0, "empty");

        // printable "Hi!"
        load('{8'h03, 8'h48, 8'h69, 8'h21});
        run_msg(3, 0, 1'b0, "hi");

        // boundary characters
        load('{8'h04, 8'h20, 8'h7E, 8'h7F, 8'h41});
        run_msg(4, 0, 1'b0, "bnd7f");
        load('{8'h04, 8'h20, 8'h7E, 8'h1F, 8'h41});
        run_msg(4, 0, 1'b0, "bnd1f");
        load('{8'h02, 8'h20, 8'h7E});
        run_msg(2, 0, 1'b0, "bndok");

        // backpressure on first byte with en pulsed mid-stream
        load('{8'h02, 8'h55, 8'h0A});
        run_msg(2, 2, 1'b1, "bp");
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_no_restart", {31'b0, rdy}, 32'd1);

        // randomized messages under random backpressure
        for (int t = 0; t < 8; t++) begin
            int L = (t == 0) ? 1 : $urandom_range(0, 24);
            img.delete();
            img.push_back(8'(L));
            for (int i = 0; i < L; i++)
                img.push_back(($urandom_range(0, 4) != 0) ? 8'($urandom_range(32, 126)) : 8'($urandom));
            load(img);
            run_msg(L, 1, 1'b0, $sformatf("rnd%0d", t));
        end

        // reset while byte 10 of a 255-byte message is valid
        img.delete();
        img.push_back(8'hFF);
        for (int i = 0; i < 255; i++) img.push_back(8'($urandom));
        load(img);
        got.delete();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (out_valid && got.size() == 9) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("mid_reach_b10", {31'b0, hit}, 32'd1);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rdy", {31'b0, rdy}, 32'd1);
        chk("mid_ok", {31'b0, pt_ok}, 32'd0);
        chk("mid_addr", {24'b0, pt_addr}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("mid_no_resume", got.size(), 32'd9);
        chk("mid_idle_valid", {31'b0, out_valid}, 32'd0);

        // full 255-byte message after the reset
        run_msg(255, 0, 1'b0, "full255");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop in case something hangs outside the bounded loops
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pt_stream_reader.md
# pt_stream_reader

Reads a length-prefixed plaintext message out of the plaintext on-chip memory written by the ARC4 PRGA stage. It streams each byte out over a valid/ready handshake. It also reports whether every byte lies in the printable ASCII range. It sits on the read port of the plaintext memory and is the consumer-side counterpart to the PRGA writer; the key-search controller uses its `pt_ok` result to accept or reject a candidate key.

## Interface
Parameters:
- `LO_CHAR`, default 8'h20: lowest printable byte, inclusive.
- `HI_CHAR`, default 8'h7E: highest printable byte, inclusive.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: start request; sampled only when `rdy`=1.
- `rdy`  out  1: block is idle and will accept `en`; also means `pt_ok` is valid.
- `pt_addr`  out  8: plaintext memory read address (registered).
- `pt_rddata`  in  8: plaintext memory read data.
- `out_valid`  out  1: `out_data` holds a message byte.
- `out_data`  out  8: message byte.
- `out_ready`  in  1: downstream accepts the byte when high together with `out_valid`.
- `pt_ok`  out  1: 1 if all bytes of the last message were in [LO_CHAR, HI_CHAR].

## Operation
- **Memory format:**
  - Address 0 holds length L (0–255).
  - Addresses 1..L hold the message bytes.
- **Memory latency:** synchronous read, one cycle. The memory registers `pt_addr` at edge k; `pt_rddata` is valid during the cycle after edge k.
- **States:** IDLE, WAIT_LEN, LEN, WAIT_B, BYTE, OUT, FIN.
- **IDLE:** `rdy`=1. On `en`=1: `pt_addr`<=0, `rdy`<=0, `pt_ok`<=0, internal ok accumulator <=1, go to WAIT_LEN. `en`=0 stays in IDLE.
- **WAIT_LEN:** go to LEN.
- **LEN:** latch len<=`pt_rddata`.
  - If `pt_rddata`==0, go to FIN.
  - Otherwise idx<=1, `pt_addr`<=1, go to WAIT_B.
- **WAIT_B:** go to BYTE.
- **BYTE:**
  - `out_data`<=`pt_rddata`, `out_valid`<=1.
  - Accumulator <= accumulator AND (LO_CHAR <= `pt_rddata` <= HI_CHAR), compared unsigned.
  - Go to OUT.
- **OUT:** hold `out_valid` and `out_data` stable while `out_ready`=0. When `out_ready`=1:
  - `out_valid`<=0.
  - If idx==len, go to FIN.
  - Otherwise idx<=idx+1, `pt_addr`<=idx+1, go to WAIT_B.
- **FIN:** `pt_ok`<=accumulator, `rdy`<=1, go to IDLE.
- **Width rules:**
  - idx and len are 8-bit; the idx==len compare happens before increment, so L=255 ends at address 255 with no wrap.
  - Memory is never read beyond address L.
- **Empty message:** L=0 produces no `out_valid` pulse and gives `pt_ok`=1.
- **No abort:** a non-printable byte does not stop the stream; all L bytes are always delivered.
- **en while busy:** `en` while `rdy`=0 is ignored and does not queue.
- **Writes:** the block never writes memory.

## Timing
- **Reset values** (applied at the rising edge with `rst`=1; `rst` overrides all other inputs):
  - state=IDLE, `rdy`=1, `out_valid`=0, `out_data`=0, `pt_addr`=0, `pt_ok`=0.
  - idx=0, len=0, accumulator=1.
- **Start:** `en` sampled at edge E0 gives `rdy`=0 after E0.
- **Completion** with `out_ready` held high: `rdy`=1 after edge E(3+3L).
  - L=0: after E3.
  - L=1: `out_valid`=1 from E4 to E5; `rdy`=1 after E6.
- **Throughput:** 3 cycles per byte with no backpressure. Each cycle of `out_ready`=0 in OUT adds exactly one cycle.
- **Handshake:** a transfer occurs on an edge where `out_valid`=1 and `out_ready`=1. `out_valid` never drops without a transfer except on reset.
- **Result validity:** `pt_ok` changes only on the FIN→IDLE edge (set to the result) and on a start edge (cleared to 0). It is stable whenever `rdy`=1.
- **Reset mid-operation:** the next edge gives the reset values. No further bytes are emitted and the message is not resumed.

## Test plan
- **Reset and idle:**
  - Stimulus: assert `rst` 2 cycles with `en`=1, then hold `en`=0 10 cycles.
  - Response: `rdy`=1, `out_valid`=0, `pt_ok`=0, `pt_addr`=0 throughout.
- **Empty message:**
  - Stimulus: mem[0]=0; pulse `en`.
  - Response: no `out_valid`; `rdy`=1 exactly 3 edges after the start edge; `pt_ok`=1.
- **Printable message:**
  - Stimulus: mem = {3, 8'h48, 8'h69, 8'h21}, `out_ready`=1.
  - Response: bytes 48, 69, 21 in order, each `out_valid` for one cycle; `rdy`=1 after E12; `pt_ok`=1.
- **Boundary characters:**
  - Stimulus: mem = {4, 8'h20, 8'h7E, 8'h7F, 8'h41}.
  - Response: all 4 bytes streamed; `pt_ok`=0.
  - Repeat with byte 8'h1F in place of 8'h7F: `pt_ok`=0.
  - Repeat with only 8'h20 and 8'h7E: `pt_ok`=1.
- **Backpressure and ignored en:**
  - Stimulus: L=2; hold `out_ready`=0 for 5 cycles on the first byte; pulse `en` mid-stream.
  - Response: `out_data` stable and `out_valid`=1 for 6 cycles; `rdy` returns exactly 5 cycles later than the no-stall case; no restart.
- **Reset mid-stream:**
  - Stimulus: L=255; assert `rst` for one cycle while `out_valid`=1 on byte 10.
  - Response: next cycle `out_valid`=0, `rdy`=1, `pt_ok`=0, `pt_addr`=0. A subsequent `en` restarts cleanly from address 0 and, with L=255, reads addresses up to 255 without wrap.
